// File: rtl/memory_pkg.sv
// Shared types and constants for the two-port memory and its read pipeline.
package memory_pkg;

  typedef enum logic [0:0] {
    MEM_INIT  = 1'b0,
    MEM_READY = 1'b1
  } mem_state_e;

  localparam int unsigned RD_LATENCY_MIN = 1;
  localparam int unsigned RD_LATENCY_MAX = 4;

  function automatic int unsigned be_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/memory_rd_pipe.sv
// Read-data delay line: RD_LATENCY valid/data stages, flushed by async reset.
module memory_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  vld_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [RD_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];

  // Data stages load only behind a valid so the output holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= vld_i;
      if (vld_i) begin
        data_q[0] <= data_i;
      end
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign vld_o  = vld_q[RD_LATENCY-1];
  assign data_o = data_q[RD_LATENCY-1];

endmodule

// File: rtl/memory_2p.sv
// One-write/one-read port memory with byte enables, write-first collision
// bypass, optional post-reset clear sequence and sticky access-error flag.
module memory_2p
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 2 ** ADDR_WIDTH,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RST = 1,
  localparam int unsigned BE_WIDTH    = be_width(DATA_WIDTH)
) (
  input  logic                  memory_clk,
  input  logic                  memory_rst,
  input  logic                  memory_wr_en,
  input  logic [ADDR_WIDTH-1:0] memory_wr_addr,
  input  logic [DATA_WIDTH-1:0] memory_wr_data,
  input  logic [BE_WIDTH-1:0]   memory_wr_be,
  input  logic                  memory_rd_en,
  input  logic [ADDR_WIDTH-1:0] memory_rd_addr,
  output logic                  memory_vld_out,
  output logic [DATA_WIDTH-1:0] memory_data_out,
  output logic                  memory_ready,
  output logic                  memory_err
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam mem_state_e RST_STATE = (CLEAR_ON_RST != 0) ? MEM_INIT : MEM_READY;

  if ((DATA_WIDTH % 8) != 0) begin : g_chk_dw
    $error("memory_2p: DATA_WIDTH must be a multiple of 8");
  end
  if ((DEPTH < 2) || (DEPTH > 2 ** ADDR_WIDTH)) begin : g_chk_depth
    $error("memory_2p: DEPTH out of range 2..2**ADDR_WIDTH");
  end
  if ((RD_LATENCY < RD_LATENCY_MIN) || (RD_LATENCY > RD_LATENCY_MAX)) begin : g_chk_lat
    $error("memory_2p: RD_LATENCY out of range");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  mem_state_e            state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  rd_vld0_q;
  logic [DATA_WIDTH-1:0] rd_data0_q;

  logic                  init_wr_c;
  logic                  wr_in_range_c, rd_in_range_c;
  logic                  wr_acc_c, rd_acc_c;
  logic [IDX_W-1:0]      wr_idx_c, rd_idx_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_WIDTH-1:0]   be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(BE_WIDTH); i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign wr_idx_c      = memory_wr_addr[IDX_W-1:0];
  assign rd_idx_c      = memory_rd_addr[IDX_W-1:0];
  assign wr_in_range_c = ({1'b0, memory_wr_addr} < (ADDR_WIDTH+1)'(DEPTH));
  assign rd_in_range_c = ({1'b0, memory_rd_addr} < (ADDR_WIDTH+1)'(DEPTH));

  // Init sequencing, access acceptance and error detection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    init_wr_c = 1'b0;
    wr_acc_c  = 1'b0;
    rd_acc_c  = 1'b0;

    case (state_q)
      MEM_INIT: begin
        init_wr_c = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = MEM_READY;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = MEM_READY;
      end
    endcase

    ready_d = (state_d == MEM_READY);

    if (ready_q) begin
      wr_acc_c = memory_wr_en && wr_in_range_c;
      rd_acc_c = memory_rd_en;
      if ((memory_wr_en && !wr_in_range_c) || (memory_rd_en && !rd_in_range_c)) begin
        err_d = 1'b1;
      end
    end else if (memory_wr_en || memory_rd_en) begin
      err_d = 1'b1;
    end
  end

  // Write-first: a same-address write in this cycle is merged into the read word.
  always_comb begin
    rd_word_c = '0;
    if (rd_in_range_c) begin
      rd_word_c = mem_q[rd_idx_c];
      if (wr_acc_c && (wr_idx_c == rd_idx_c)) begin
        rd_word_c = merge_bytes(mem_q[rd_idx_c], memory_wr_data, memory_wr_be);
      end
    end
  end

  always_ff @(posedge memory_clk or negedge memory_rst) begin
    if (!memory_rst) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_vld0_q  <= 1'b0;
      rd_data0_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rd_vld0_q <= rd_acc_c;
      if (rd_acc_c) begin
        rd_data0_q <= rd_word_c;
      end
    end
  end

  // Storage array has no reset; clearing is done by the init sequence.
  always_ff @(posedge memory_clk) begin
    if (init_wr_c) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc_c) begin
      for (int i = 0; i < int'(BE_WIDTH); i++) begin
        if (memory_wr_be[i]) begin
          mem_q[wr_idx_c][8*i +: 8] <= memory_wr_data[8*i +: 8];
        end
      end
    end
  end

  memory_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk    (memory_clk),
    .rst_n  (memory_rst),
    .vld_i  (rd_vld0_q),
    .data_i (rd_data0_q),
    .vld_o  (memory_vld_out),
    .data_o (memory_data_out)
  );

  assign memory_ready = ready_q;
  assign memory_err   = err_q;

endmodule
